// File: rtl/store_align_unit_pkg.sv
// Shared store/load alignment package: size-mask constants, FSM state
// encoding and small mask helpers used by the store alignment unit.
package store_align_unit_pkg;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE
    } state_t;

    function automatic logic mask_legal(input logic [3:0] m);
        return (m == MASK_BYTE) || (m == MASK_HALF) || (m == MASK_WORD);
    endfunction

    // Expand a byte-enable mask into a 32-bit data mask.
    function automatic logic [31:0] lane_fill(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// LSU request + data-memory write port bundle for the store align unit.
// slave: the unit itself; master: the LSU/memory side driving it.
interface store_align_unit_if #(
    parameter int ADDR_W = 32
);

    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_data;
    logic [3:0]        i_mask;
    logic              o_mem_req;
    logic              i_mem_ack;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_valid, i_addr, i_data, i_mask, i_mem_ack,
        output o_ready, o_mem_req, o_mem_addr, o_mem_wdata,
        output o_mem_bmask, o_done, o_err
    );

    modport master (
        output i_valid, i_addr, i_data, i_mask, i_mem_ack,
        input  o_ready, o_mem_req, o_mem_addr, o_mem_wdata,
        input  o_mem_bmask, o_done, o_err
    );

endinterface

// File: rtl/store_align_unit_lane_shift.sv
// store_lane_shift: combinational byte-lane placement of store data/mask.
// Ports: i_off/i_mask/i_data in; o_wide_mask, o_wide_data, o_split out.
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_data,
    output logic [7:0]  o_wide_mask,
    output logic [63:0] o_wide_data,
    output logic        o_split
);

    logic [31:0] data_clean;

    // Bytes above the store size are cleared so unused lanes write as 0.
    assign data_clean  = i_data & lane_fill(i_mask);
    assign o_wide_mask = {4'b0000, i_mask} << i_off;
    assign o_wide_data = {32'd0, data_clean} << {i_off, 3'b000};
    assign o_split     = |o_wide_mask[7:4];

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: takes one LSU store, issues 1 or 2 word-aligned
// write beats under req/ack, then pulses o_done (o_err on rejection).
// Ports: i_clk, i_reset (async, active-high), bus (store_align_unit_if.slave).
// STORE_ALIGN_MISALIGN_SPLIT_EN: when defined, word-crossing stores are
// split into two beats; otherwise they are rejected with o_err.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    store_align_unit_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        bmask_q, bmask_d;
    logic              err_q, err_d;

    logic [7:0]        wide_mask;
    logic [63:0]       wide_data;
    logic              split;
    logic              accept;
    logic              reject;

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    logic [31:0]       hi_wdata_q, hi_wdata_d;
    logic [3:0]        hi_bmask_q, hi_bmask_d;
    logic              split_q, split_d;
`else
    logic              unused_hi;
    assign unused_hi = ^{wide_data[63:32], wide_mask[7:4]};
`endif

    store_lane_shift u_shift (
        .i_off       (bus.i_addr[1:0]),
        .i_mask      (bus.i_mask),
        .i_data      (bus.i_data),
        .o_wide_mask (wide_mask),
        .o_wide_data (wide_data),
        .o_split     (split)
    );

    assign accept = bus.i_valid && (state_q == IDLE);

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    assign reject = !mask_legal(bus.i_mask);
`else
    assign reject = !mask_legal(bus.i_mask) || split;
`endif

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        err_d   = 1'b0;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        hi_wdata_d = hi_wdata_q;
        hi_bmask_d = hi_bmask_q;
        split_d    = split_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BEAT0;
                        maddr_d = {bus.i_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = wide_data[31:0];
                        bmask_d = wide_mask[3:0];
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
                        hi_wdata_d = wide_data[63:32];
                        hi_bmask_d = wide_mask[7:4];
                        split_d    = split;
`endif
                    end
                end
            end
            BEAT0: begin
                if (bus.i_mem_ack) begin
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state_d = BEAT1;
                        maddr_d = maddr_q + ADDR_W'(4);
                        wdata_d = hi_wdata_q;
                        bmask_d = hi_bmask_q;
                    end else begin
                        state_d = DONE;
                        maddr_d = '0;
                        wdata_d = '0;
                        bmask_d = '0;
                    end
`else
                    state_d = DONE;
                    maddr_d = '0;
                    wdata_d = '0;
                    bmask_d = '0;
`endif
                end
            end
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (bus.i_mem_ack) begin
                    state_d = DONE;
                    maddr_d = '0;
                    wdata_d = '0;
                    bmask_d = '0;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            maddr_q <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            err_q   <= err_d;
        end
    end

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hi_wdata_q <= '0;
            hi_bmask_q <= '0;
            split_q    <= 1'b0;
        end else begin
            hi_wdata_q <= hi_wdata_d;
            hi_bmask_q <= hi_bmask_d;
            split_q    <= split_d;
        end
    end
`endif

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_mem_req   = (state_q == BEAT0) || (state_q == BEAT1);
    assign bus.o_mem_addr  = maddr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_bmask = bmask_q;
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed testbench for store_align_unit.
// Follows STORE_ALIGN_MISALIGN_SPLIT_EN to pick split vs reject expectations.
module tb_store_align_unit;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    store_align_unit_if #(.ADDR_W(32)) bus ();

    store_align_unit #(.ADDR_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
        bus.i_valid = 1'b1;
        bus.i_addr  = a;
        bus.i_data  = d;
        bus.i_mask  = m;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        chk({tag, ".req"}, 64'(bus.o_mem_req), 64'd1);
        chk({tag, ".addr"}, 64'(bus.o_mem_addr), 64'(a));
        chk({tag, ".wdata"}, 64'(bus.o_mem_wdata), 64'(d));
        chk({tag, ".bmask"}, 64'(bus.o_mem_bmask), 64'(m));
        chk({tag, ".rdy"}, 64'(bus.o_ready), 64'd0);
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, ".req"}, 64'(bus.o_mem_req), 64'd0);
        chk({tag, ".addr"}, 64'(bus.o_mem_addr), 64'd0);
        chk({tag, ".wdata"}, 64'(bus.o_mem_wdata), 64'd0);
        chk({tag, ".bmask"}, 64'(bus.o_mem_bmask), 64'd0);
        chk({tag, ".done"}, 64'(bus.o_done), 64'd0);
        chk({tag, ".err"}, 64'(bus.o_err), 64'd0);
        chk({tag, ".rdy"}, 64'(bus.o_ready), 64'd1);
    endtask

    task automatic fin_done(input string tag);
        chk({tag, ".done"}, 64'(bus.o_done), 64'd1);
        chk({tag, ".reqlo"}, 64'(bus.o_mem_req), 64'd0);
        tick();
        chk({tag, ".done1"}, 64'(bus.o_done), 64'd0);
        chk({tag, ".rdy1"}, 64'(bus.o_ready), 64'd1);
    endtask

    task automatic rejected(input string tag);
        tick();
        chk({tag, ".err"}, 64'(bus.o_err), 64'd1);
        chk({tag, ".req"}, 64'(bus.o_mem_req), 64'd0);
        chk({tag, ".rdy"}, 64'(bus.o_ready), 64'd1);
        tick();
        chk({tag, ".err1"}, 64'(bus.o_err), 64'd0);
        chk({tag, ".req1"}, 64'(bus.o_mem_req), 64'd0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_addr    = '0;
        bus.i_data    = '0;
        bus.i_mask    = '0;
        bus.i_mem_ack = 1'b0;
        #2;
        idle_outs("rst");
        tick();
        rst = 1'b0;

        // ack high while idle must not start anything
        bus.i_mem_ack = 1'b1;
        tick();
        tick();
        idle_outs("idle_ack");

        // SW aligned: req at N+1, done at N+2
        send(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        beat("sw", 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        tick();
        fin_done("sw");

        // SB to top lane; garbage above the byte must not reach memory
        send(32'h0000_1003, 32'hFFFF_FFA5, 4'b0001);
        beat("sb", 32'h0000_1000, 32'hA500_0000, 4'b1000);
        tick();
        fin_done("sb");

        // SH at offset 1 stays inside the word
        send(32'h0000_1001, 32'h0000_BEEF, 4'b0011);
        beat("sh1", 32'h0000_1000, 32'h00BE_EF00, 4'b0110);
        tick();
        fin_done("sh1");

        // illegal size mask
        send(32'h0000_1000, 32'h1234_5678, 4'b0101);
        chk("ill.n1req", 64'(bus.o_mem_req), 64'd0);
        chk("ill.n1err", 64'(bus.o_err), 64'd1);
        tick();
        chk("ill.n2err", 64'(bus.o_err), 64'd0);
        chk("ill.n2req", 64'(bus.o_mem_req), 64'd0);

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        // SH crossing a word: two back-to-back beats, done at N+3
        send(32'h0000_2003, 32'h0000_1234, 4'b0011);
        beat("shx0", 32'h0000_2000, 32'h3400_0000, 4'b1000);
        tick();
        beat("shx1", 32'h0000_2004, 32'h0000_0012, 4'b0001);
        tick();
        fin_done("shx");

        // SW crossing the top of the address space wraps to 0
        send(32'hFFFF_FFFE, 32'h1122_3344, 4'b1111);
        beat("wrap0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        tick();
        beat("wrap1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
        tick();
        fin_done("wrap");
`else
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h0000_2003;
        bus.i_data  = 32'h0000_1234;
        bus.i_mask  = 4'b0011;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("shx.err", 64'(bus.o_err), 64'd1);
        chk("shx.req", 64'(bus.o_mem_req), 64'd0);
        chk("shx.rdy", 64'(bus.o_ready), 64'd1);
        tick();
        chk("shx.err1", 64'(bus.o_err), 64'd0);
        chk("shx.req1", 64'(bus.o_mem_req), 64'd0);

        send(32'hFFFF_FFFE, 32'h1122_3344, 4'b1111);
        chk("wrap.err", 64'(bus.o_err), 64'd1);
        chk("wrap.req", 64'(bus.o_mem_req), 64'd0);
        tick();
        chk("wrap.err1", 64'(bus.o_err), 64'd0);
`endif

        // stalled ack with a second request waiting
        bus.i_mem_ack = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_addr  = 32'h0000_3000;
        bus.i_data  = 32'hCAFE_F00D;
        bus.i_mask  = 4'b1111;
        tick();
        bus.i_addr  = 32'h0000_4004;
        bus.i_data  = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("stall%0d", i), 32'h0000_3000,
                 32'hCAFE_F00D, 4'b1111);
            tick();
        end
        beat("stall3", 32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
        bus.i_mem_ack = 1'b1;
        tick();
        chk("stall.done", 64'(bus.o_done), 64'd1);
        chk("stall.rdy", 64'(bus.o_ready), 64'd0);
        tick();
        chk("stall.rdy1", 64'(bus.o_ready), 64'd1);
        chk("stall.req1", 64'(bus.o_mem_req), 64'd0);
        tick();
        bus.i_valid = 1'b0;
        beat("second", 32'h0000_4004, 32'h0BAD_F00D, 4'b1111);
        tick();
        fin_done("second");

        // async reset in the middle of a beat
        bus.i_mem_ack = 1'b0;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        send(32'h0000_2003, 32'h0000_1234, 4'b0011);
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        beat("mid1", 32'h0000_2004, 32'h0000_0012, 4'b0001);
`else
        send(32'h0000_5000, 32'h5555_AAAA, 4'b1111);
        beat("mid0", 32'h0000_5000, 32'h5555_AAAA, 4'b1111);
`endif
        #2;
        rst = 1'b1;
        #1;
        idle_outs("arst");
        tick();
        rst = 1'b0;
        bus.i_mem_ack = 1'b1;
        tick();
        idle_outs("arst1");
        tick();
        idle_outs("arst2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
